// File: rtl/ddr_axi_burst_master.sv
// rtl/ddr_axi_burst_master.sv - single-outstanding request port to fixed 4-beat INCR AXI bursts
// Optional statistics counters are enabled by defining DDR_AXI_MASTER_STATS_EN.
module ddr_axi_burst_master
`ifdef DDR_AXI_MASTER_STATS_EN
#(
   parameter int STAT_W = 16
)
`endif
(
   input  logic         ACLK,
   input  logic         ARESET,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_write,
   input  logic [31:0]  cmd_addr,
   input  logic [127:0] cmd_wdata,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_write,
   output logic         rsp_err,
   output logic [127:0] rsp_rdata,
   output logic [31:0]  M_AWADDR,
   output logic [3:0]   M_AWLEN,
   output logic         M_AWVALID,
   input  logic         M_AWREADY,
   output logic [31:0]  M_WDATA,
   output logic [3:0]   M_WSTRB,
   output logic         M_WLAST,
   output logic         M_WVALID,
   input  logic         M_WREADY,
   input  logic [1:0]   M_BRESP,
   input  logic         M_BVALID,
   output logic         M_BREADY,
   output logic [31:0]  M_ARADDR,
   output logic [3:0]   M_ARLEN,
   output logic         M_ARVALID,
   input  logic         M_ARREADY,
   input  logic [31:0]  M_RDATA,
   input  logic [1:0]   M_RRESP,
   input  logic         M_RLAST,
   input  logic         M_RVALID,
   output logic         M_RREADY
`ifdef DDR_AXI_MASTER_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_wr_cnt,
   output logic [STAT_W-1:0] stat_rd_cnt,
   output logic [STAT_W-1:0] stat_err_cnt
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_ADDR,
      ST_W_DATA,
      ST_W_RESP,
      ST_R_ADDR,
      ST_R_DATA,
      ST_RSP
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     beat_q, beat_d;
   logic           write_q, write_d;
   logic           err_q, err_d;
   logic [31:0]    addr_q, addr_d;
   logic [127:0]   wdata_q, wdata_d;
   logic [127:0]   rdata_q, rdata_d;
   logic           last_beat;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q <= ST_IDLE;
         beat_q  <= 2'd0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 128'h0;
         rdata_q <= 128'h0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         write_q <= write_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      write_d   = write_q;
      err_d     = err_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      last_beat = (beat_q == 2'd3);
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               write_d = cmd_write;
               addr_d  = cmd_addr & 32'hFFFF_FFF0;
               wdata_d = cmd_wdata;
               rdata_d = 128'h0;
               err_d   = 1'b0;
               beat_d  = 2'd0;
               state_d = cmd_write ? ST_W_ADDR : ST_R_ADDR;
            end
         end
         ST_W_ADDR: if (M_AWREADY) state_d = ST_W_DATA;
         ST_W_DATA: begin
            if (M_WREADY) begin
               beat_d = beat_q + 2'd1;
               if (last_beat) state_d = ST_W_RESP;
            end
         end
         ST_W_RESP: begin
            if (M_BVALID) begin
               err_d   = err_q | (M_BRESP != 2'b00);
               state_d = ST_RSP;
            end
         end
         ST_R_ADDR: if (M_ARREADY) state_d = ST_R_DATA;
         ST_R_DATA: begin
            if (M_RVALID) begin
               rdata_d[{beat_q, 5'b0} +: 32] = M_RDATA;
               err_d  = err_q | (M_RRESP != 2'b00);
               beat_d = beat_q + 2'd1;
               // Early RLAST or a missing RLAST on beat 3 both terminate with an error.
               if (M_RLAST || last_beat) begin
                  err_d   = err_q | (M_RRESP != 2'b00) | (M_RLAST != last_beat);
                  beat_d  = 2'd0;
                  state_d = ST_RSP;
               end
            end
         end
         ST_RSP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_ready = (state_q == ST_IDLE) && !ARESET;
   assign rsp_valid = (state_q == ST_RSP);
   assign rsp_write = write_q;
   assign rsp_err   = err_q;
   assign rsp_rdata = rdata_q;

   assign M_AWVALID = (state_q == ST_W_ADDR);
   assign M_AWADDR  = addr_q;
   assign M_AWLEN   = M_AWVALID ? 4'd3 : 4'd0;
   assign M_WVALID  = (state_q == ST_W_DATA);
   assign M_WDATA   = wdata_q[{beat_q, 5'b0} +: 32];
   assign M_WSTRB   = {4{M_WVALID}};
   assign M_WLAST   = M_WVALID && last_beat;
   assign M_BREADY  = (state_q == ST_W_RESP);
   assign M_ARVALID = (state_q == ST_R_ADDR);
   assign M_ARADDR  = addr_q;
   assign M_ARLEN   = M_ARVALID ? 4'd3 : 4'd0;
   assign M_RREADY  = (state_q == ST_R_DATA);

`ifdef DDR_AXI_MASTER_STATS_EN
   logic [STAT_W-1:0] stat_wr_q, stat_wr_d;
   logic [STAT_W-1:0] stat_rd_q, stat_rd_d;
   logic [STAT_W-1:0] stat_err_q, stat_err_d;
   logic              rsp_fire;

   assign rsp_fire = rsp_valid && rsp_ready;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         stat_wr_q  <= '0;
         stat_rd_q  <= '0;
         stat_err_q <= '0;
      end else begin
         stat_wr_q  <= stat_wr_d;
         stat_rd_q  <= stat_rd_d;
         stat_err_q <= stat_err_d;
      end
   end

   always_comb begin
      stat_wr_d  = stat_wr_q;
      stat_rd_d  = stat_rd_q;
      stat_err_d = stat_err_q;
      if (rsp_fire) begin
         if (write_q) stat_wr_d = stat_wr_q + 1'b1;
         else         stat_rd_d = stat_rd_q + 1'b1;
         if (err_q)   stat_err_d = stat_err_q + 1'b1;
      end
   end

   assign stat_wr_cnt  = stat_wr_q;
   assign stat_rd_cnt  = stat_rd_q;
   assign stat_err_cnt = stat_err_q;
`endif

endmodule

// File: doc/ddr_axi_burst_master.md
# ddr_axi_burst_master

Upstream AXI master for the DDR slave controller. Turns a single-outstanding request/response port into fixed 4-beat INCR AXI write or read bursts on the S0 channel set of the DDR AXI slave. A write returns the BRESP outcome; a read returns four 32-bit beats packed into 128 bits. System agents reach DDR memory through this block, without implementing AXI handshakes themselves.

## Interface
- STAT_W, 16, width of statistics counters (used only with DDR_AXI_MASTER_STATS_EN)
- ACLK  in  1  single clock for all logic
- ARESET  in  1  asynchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1  request handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  32  byte address; bits [3:0] forced to 0 on the bus
- cmd_wdata  in  128  write beats; [31:0] = beat 0 … [127:96] = beat 3
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_write  out  1  echoes cmd_write of the completed request
- rsp_err  out  1  nonzero BRESP/RRESP or RLAST mismatch
- rsp_rdata  out  128  read beats, same packing as cmd_wdata; 0 for writes
- M_AWADDR, M_AWLEN[3:0], M_AWVALID out; M_AWREADY in
- M_WDATA[31:0], M_WSTRB[3:0], M_WLAST, M_WVALID out; M_WREADY in
- M_BRESP[1:0], M_BVALID in; M_BREADY out
- M_ARADDR, M_ARLEN[3:0], M_ARVALID out; M_ARREADY in
- M_RDATA[31:0], M_RRESP[1:0], M_RLAST, M_RVALID in; M_RREADY out
- stat_wr_cnt, stat_rd_cnt, stat_err_cnt  out  STAT_W  present only with DDR_AXI_MASTER_STATS_EN

## Operation
- FSM states: IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA, RSP.
- IDLE: cmd_ready=1. Handshake latches cmd_* and clears rdata/err. Goes to W_ADDR if cmd_write, else R_ADDR.
- W_ADDR: M_AWVALID=1, AWLEN=3. Goes to W_DATA on AWREADY.
- W_DATA: M_WVALID=1, WSTRB=4'hF, 2-bit beat counter selects the lane, WLAST=(beat==3). The beat advances on each WREADY. Goes to W_RESP on the beat-3 handshake.
- W_RESP: M_BREADY=1. On BVALID, err |= (BRESP!=0). Goes to RSP.
- R_ADDR: M_ARVALID=1, ARLEN=3. Goes to R_DATA on ARREADY.
- R_DATA: M_RREADY=1. Each RVALID stores RDATA into lane[beat] and sets err |= (RRESP!=0). The burst ends on RLAST or the beat-3 handshake, whichever comes first. err is set if the two do not coincide; lanes not received stay 0. Goes to RSP.
- RSP: rsp_valid=1, held until rsp_ready. Returns to IDLE.
- No VALID drops before its READY. AW/AR address is held stable while valid.
- BVALID/RVALID outside W_RESP/R_DATA are ignored, because BREADY/RREADY are low there.

## Timing
- All outputs are registered or decoded from the state register. All are 0 under reset: state IDLE, all VALIDs 0, BREADY/RREADY 0, rsp_* 0, counters 0.
- cmd_ready is high in IDLE from the first cycle after ARESET deasserts.
- Accept at edge n → AWVALID/ARVALID high from cycle n+1.
- AW handshake at edge k → WVALID with beat 0 from k+1. Beats can run back-to-back: WVALID stays high and the next beat is presented the cycle after each handshake.
- Last data/response handshake at edge m → rsp_valid from m+1. rsp handshake at edge p → cmd_ready from p+1.
- Minimum write latency with zero-wait slave: accept→rsp_valid = 7 cycles. Minimum read latency = 6 cycles.
- ARESET mid-burst: immediate return to IDLE, the in-flight burst is discarded, and no response is issued.

## Configuration
- DDR_AXI_MASTER_STATS_EN defined:
  - stat_wr_cnt counts completed writes and stat_rd_cnt counts completed reads, each at the rsp handshake.
  - stat_err_cnt counts responses with rsp_err=1.
  - All three are wrap-around STAT_W counters, cleared by ARESET.
- Not defined: the three ports and their counters are absent; behaviour is otherwise identical.

## Test plan
- Write 0x0000_0000 with DEAD_BEEF, C0DE_CAFE, 1234_5678, 8765_4321 → AWLEN=3, four W beats in order, WLAST on beat 3 only; response has rsp_write=1 and rsp_err=0.
- Read 0x0000_0000 after that write → response has rsp_rdata = 8765_4321_1234_5678_C0DE_CAFE_DEAD_BEEF and rsp_err=0.
- cmd_addr=0x0000_100C write with AWREADY/WREADY stalled 3 cycles each → AWADDR=0x0000_1000; VALID and data held stable through every stall.
- Slave returns RLAST on beat 1 with RRESP=2'b10 → burst ends after 2 beats; rsp_rdata upper 64 bits = 0 and rsp_err=1.
- ARESET pulsed during W_DATA beat 2 → all outputs 0 at once and no rsp_valid; a following write completes normally.
- With DDR_AXI_MASTER_STATS_EN defined, run 2 writes, 1 read and 1 error read → stat_wr_cnt=2, stat_rd_cnt=2, stat_err_cnt=1.
